// File: rtl/icache_ctrl.sv
// icache_ctrl: miss sequencing for a 32-entry x 64-bit direct-mapped instruction cache.
// Define ICACHE_PREFETCH_EN to add a next-line prefetch after every demand fill.
module icache_ctrl #(
    parameter int unsigned MEM_TAG_W = 4,
    parameter logic [1:0]  BUS_LOAD  = 2'h1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 proc2Icache_en,
    input  logic [63:0]          proc2Icache_addr,
    output logic [63:0]          Icache_data_out,
    output logic                 Icache_valid_out,
    output logic [1:0]           proc2Imem_command,
    output logic [63:0]          proc2Imem_addr,
    input  logic [MEM_TAG_W-1:0] Imem2proc_response,
    input  logic [MEM_TAG_W-1:0] Imem2proc_tag,
    input  logic [63:0]          Imem2proc_data,
    output logic [4:0]           rd1_idx,
    output logic [7:0]           rd1_tag,
    input  logic [63:0]          rd1_data,
    input  logic                 rd1_valid,
    output logic                 wr1_en,
    output logic [4:0]           wr1_idx,
    output logic [7:0]           wr1_tag,
    output logic [63:0]          wr1_data
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned LINE_W = IDX_W + TAG_W;
    localparam logic [1:0]  BUS_NONE = 2'h0;

`ifdef ICACHE_PREFETCH_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, PF_REQ, PF_WAIT} state_e;
`else
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
`endif

    state_e               state_q, state_d;
    logic [TAG_W-1:0]     l_tag_q, l_tag_d;
    logic [IDX_W-1:0]     l_idx_q, l_idx_d;
    logic [MEM_TAG_W-1:0] m_tag_q, m_tag_d;

    logic [IDX_W-1:0]     f_idx;
    logic [TAG_W-1:0]     f_tag;
    logic                 demand_miss;
    logic                 same_line;
    logic                 beat_match;
    logic                 fill;
    logic                 bypass;
    logic [1:0]           command;
    logic                 unused_addr_bits;
`ifdef ICACHE_PREFETCH_EN
    logic [LINE_W-1:0]    next_line;
`endif

    assign f_idx = proc2Icache_addr[7:3];
    assign f_tag = proc2Icache_addr[15:8];
    assign unused_addr_bits = ^{proc2Icache_addr[63:16], proc2Icache_addr[2:0]};

    assign demand_miss = proc2Icache_en & ~rd1_valid;
    assign same_line   = proc2Icache_en & (f_idx == l_idx_q) & (f_tag == l_tag_q);
    // m_tag of 0 means nothing outstanding, so stray idle-tag beats never match
    assign beat_match  = (m_tag_q != '0) & (Imem2proc_tag == m_tag_q);
`ifdef ICACHE_PREFETCH_EN
    // Tag and index increment as one field so idx 31 carries into the tag
    assign next_line   = {l_tag_q, l_idx_q} + LINE_W'(1);
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            l_tag_q <= '0;
            l_idx_q <= '0;
            m_tag_q <= '0;
        end else begin
            state_q <= state_d;
            l_tag_q <= l_tag_d;
            l_idx_q <= l_idx_d;
            m_tag_q <= m_tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        l_tag_d = l_tag_q;
        l_idx_d = l_idx_q;
        m_tag_d = m_tag_q;
        command = BUS_NONE;
        fill    = 1'b0;
        case (state_q)
            IDLE: begin
                if (demand_miss) begin
                    l_tag_d = f_tag;
                    l_idx_d = f_idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!same_line) begin
                    state_d = IDLE;
                end else begin
                    command = BUS_LOAD;
                    if (Imem2proc_response != '0) begin
                        m_tag_d = Imem2proc_response;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (beat_match) begin
                    fill    = 1'b1;
                    m_tag_d = '0;
`ifdef ICACHE_PREFETCH_EN
                    {l_tag_d, l_idx_d} = next_line;
                    state_d = PF_REQ;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef ICACHE_PREFETCH_EN
            PF_REQ: begin
                command = BUS_LOAD;
                if (Imem2proc_response != '0) begin
                    m_tag_d = Imem2proc_response;
                    state_d = PF_WAIT;
                end else if (demand_miss) begin
                    l_tag_d = f_tag;
                    l_idx_d = f_idx;
                    state_d = REQ;
                end
            end
            PF_WAIT: begin
                if (beat_match) begin
                    fill    = 1'b1;
                    m_tag_d = '0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Fill-cycle bypass lets the fetch see the returning beat before the array holds it
    assign bypass = fill & same_line;

    assign rd1_idx           = f_idx;
    assign rd1_tag           = f_tag;
    assign Icache_valid_out  = (proc2Icache_en & rd1_valid) | bypass;
    assign Icache_data_out   = bypass ? Imem2proc_data : rd1_data;
    assign proc2Imem_command = command;
    assign proc2Imem_addr    = {48'd0, l_tag_q, l_idx_q, 3'd0};
    assign wr1_en            = fill;
    assign wr1_idx           = l_idx_q;
    assign wr1_tag           = l_tag_q;
    assign wr1_data          = fill ? Imem2proc_data : 64'd0;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed scenarios plus randomized fetch/memory traffic for icache_ctrl,
// with a behavioural cache array and memory model.
module tb_icache_ctrl;

    localparam logic [1:0] LOAD = 2'h1;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        proc2Icache_en;
    logic [63:0] proc2Icache_addr;
    logic [63:0] Icache_data_out;
    logic        Icache_valid_out;
    logic [1:0]  proc2Imem_command;
    logic [63:0] proc2Imem_addr;
    logic [3:0]  Imem2proc_response;
    logic [3:0]  Imem2proc_tag;
    logic [63:0] Imem2proc_data;
    logic [4:0]  rd1_idx;
    logic [7:0]  rd1_tag;
    logic [63:0] rd1_data;
    logic        rd1_valid;
    logic        wr1_en;
    logic [4:0]  wr1_idx;
    logic [7:0]  wr1_tag;
    logic [63:0] wr1_data;

    int n_chk  = 0;
    int n_fail = 0;

    // memory model: at most one accepted load outstanding
    bit          pend = 1'b0;
    logic [3:0]  pend_tag;
    logic [12:0] pend_line;
    int          pend_wait;

    logic        arr_v [32];
    logic [7:0]  arr_t [32];
    logic [63:0] arr_d [32];
    logic [4:0]  idx_pool [6] = '{5'd0, 5'd1, 5'd2, 5'd16, 5'd30, 5'd31};

    always #5 clock = ~clock;

    icache_ctrl #(.MEM_TAG_W(4), .BUS_LOAD(2'h1)) dut (
        .clock(clock), .reset_n(reset_n),
        .proc2Icache_en(proc2Icache_en), .proc2Icache_addr(proc2Icache_addr),
        .Icache_data_out(Icache_data_out), .Icache_valid_out(Icache_valid_out),
        .proc2Imem_command(proc2Imem_command), .proc2Imem_addr(proc2Imem_addr),
        .Imem2proc_response(Imem2proc_response), .Imem2proc_tag(Imem2proc_tag),
        .Imem2proc_data(Imem2proc_data),
        .rd1_idx(rd1_idx), .rd1_tag(rd1_tag), .rd1_data(rd1_data), .rd1_valid(rd1_valid),
        .wr1_en(wr1_en), .wr1_idx(wr1_idx), .wr1_tag(wr1_tag), .wr1_data(wr1_data)
    );

    assign rd1_valid = arr_v[rd1_idx] & (arr_t[rd1_idx] == rd1_tag);
    assign rd1_data  = arr_d[rd1_idx];

    always @(posedge clock) begin
        if (wr1_en) begin
            arr_v[wr1_idx] <= 1'b1;
            arr_t[wr1_idx] <= wr1_tag;
            arr_d[wr1_idx] <= wr1_data;
        end
    end

    function automatic logic [63:0] mem_word(input logic [12:0] line);
        return {16'hC0DE, 35'd0, line} ^ (64'(line) * 64'h9E37_79B9_7F4A_7C15);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [63:0] a, input logic [3:0] rsp,
                         input logic [3:0] bt, input logic [63:0] bd);
        @(posedge clock); #1;
        proc2Icache_en     = en;
        proc2Icache_addr   = a;
        Imem2proc_response = rsp;
        Imem2proc_tag      = bt;
        Imem2proc_data     = bd;
        #1;
    endtask

    // One cycle of fetch + memory model traffic with reference checks
    task automatic mem_cycle(input logic en, input logic [63:0] a, input bit noise,
                             input bit eager, output bit hit);
        bit beat;
        beat = 1'b0;
        @(posedge clock); #1;
        proc2Icache_en     = en;
        proc2Icache_addr   = a;
        Imem2proc_response = '0;
        Imem2proc_tag      = '0;
        Imem2proc_data     = '0;
        if (pend && pend_wait == 0) begin
            beat           = 1'b1;
            Imem2proc_tag  = pend_tag;
            Imem2proc_data = mem_word(pend_line);
        end else if (noise && $urandom_range(0, 1) == 1) begin
            Imem2proc_tag = 4'($urandom_range(1, 15));
            if (pend && Imem2proc_tag == pend_tag) Imem2proc_tag = '0;
            Imem2proc_data = {$urandom, $urandom};
        end
        #1;
        check_eq("wr_en", 64'(wr1_en), 64'(beat));
        if (beat) begin
            check_eq("wr_line", 64'({wr1_tag, wr1_idx}), 64'(pend_line));
            check_eq("wr_data", wr1_data, mem_word(pend_line));
            pend = 1'b0;
        end else if (pend) begin
            pend_wait--;
        end
        hit = Icache_valid_out;
        if (Icache_valid_out) check_eq("fetch_data", Icache_data_out, mem_word(a[15:3]));
        if (proc2Imem_command == LOAD) begin
            check_eq("ld_align", 64'({proc2Imem_addr[63:16], proc2Imem_addr[2:0]}), 64'd0);
`ifndef ICACHE_PREFETCH_EN
            check_eq("ld_line", proc2Imem_addr, {48'd0, a[15:3], 3'd0});
`endif
            if (!pend && (eager || $urandom_range(0, 2) != 0)) begin
                pend      = 1'b1;
                pend_tag  = 4'($urandom_range(1, 15));
                pend_line = proc2Imem_addr[15:3];
                pend_wait = eager ? 0 : int'($urandom_range(0, 4));
                Imem2proc_response = pend_tag;
            end
        end else begin
            check_eq("cmd_none", 64'(proc2Imem_command), 64'd0);
        end
    endtask

    task automatic fill_line(input logic [63:0] a);
        bit hit;
        bit got;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            mem_cycle(1'b1, a, 1'b0, 1'b1, hit);
            got = hit;
        end
        check_eq("fill_done", 64'(got), 64'd1);
    endtask

    task automatic settle();
        bit hit;
        for (int c = 0; c < 8; c++) mem_cycle(1'b0, 64'd0, 1'b0, 1'b1, hit);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, %0d checks done", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] hit_lines [4];
        for (int i = 0; i < 32; i++) begin
            arr_v[i] = 1'b0;
            arr_t[i] = '0;
            arr_d[i] = '0;
        end
        reset_n            = 1'b0;
        proc2Icache_en     = 1'b0;
        proc2Icache_addr   = '0;
        Imem2proc_response = '0;
        Imem2proc_tag      = 4'd5;
        Imem2proc_data     = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_cmd", 64'(proc2Imem_command), 64'd0);
        check_eq("rst_addr", proc2Imem_addr, 64'd0);
        check_eq("rst_wr_en", 64'(wr1_en), 64'd0);
        check_eq("rst_wr_line", 64'({wr1_tag, wr1_idx}), 64'd0);
        check_eq("rst_wr_data", wr1_data, 64'd0);
        check_eq("rst_valid", 64'(Icache_valid_out), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        Imem2proc_tag  = '0;
        Imem2proc_data = '0;

        // Demand miss on 0x100, fill with 0xDEAD, bypass then array hit
        drive(1'b1, 64'h100, 4'd0, 4'd0, 64'd0);
        check_eq("t1_idle_cmd", 64'(proc2Imem_command), 64'd0);
        check_eq("t1_idle_valid", 64'(Icache_valid_out), 64'd0);
        drive(1'b1, 64'h100, 4'd3, 4'd0, 64'd0);
        check_eq("t1_req_cmd", 64'(proc2Imem_command), 64'(LOAD));
        check_eq("t1_req_addr", proc2Imem_addr, 64'h100);
        drive(1'b1, 64'h100, 4'd0, 4'd0, 64'd0);
        check_eq("t1_wait_cmd", 64'(proc2Imem_command), 64'd0);
        check_eq("t1_wait_wr", 64'(wr1_en), 64'd0);
        drive(1'b1, 64'h100, 4'd0, 4'd3, 64'hDEAD);
        check_eq("t1_fill_wr", 64'(wr1_en), 64'd1);
        check_eq("t1_fill_line", 64'({wr1_tag, wr1_idx}), 64'h20);
        check_eq("t1_fill_data", wr1_data, 64'hDEAD);
        check_eq("t1_byp_valid", 64'(Icache_valid_out), 64'd1);
        check_eq("t1_byp_data", Icache_data_out, 64'hDEAD);
        drive(1'b1, 64'h100, 4'd0, 4'd0, 64'd0);
        check_eq("t1_hit_valid", 64'(Icache_valid_out), 64'd1);
        check_eq("t1_hit_data", Icache_data_out, 64'hDEAD);
        check_eq("t1_after_wr", 64'(wr1_en), 64'd0);
        settle();

        // Unaccepted request dropped when the fetch moves to another line
        drive(1'b1, 64'h180, 4'd0, 4'd0, 64'd0);
        check_eq("t2_idle_cmd", 64'(proc2Imem_command), 64'd0);
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 64'h180, 4'd0, 4'd0, 64'd0);
            check_eq("t2_hold_cmd", 64'(proc2Imem_command), 64'(LOAD));
            check_eq("t2_hold_addr", proc2Imem_addr, 64'h180);
        end
        drive(1'b1, 64'h200, 4'd0, 4'd0, 64'd0);
        check_eq("t2_drop_cmd", 64'(proc2Imem_command), 64'd0);
        drive(1'b1, 64'h200, 4'd0, 4'd0, 64'd0);
        check_eq("t2_idle2_cmd", 64'(proc2Imem_command), 64'd0);
        drive(1'b1, 64'h200, 4'd5, 4'd0, 64'd0);
        check_eq("t2_new_cmd", 64'(proc2Imem_command), 64'(LOAD));
        check_eq("t2_new_addr", proc2Imem_addr, 64'h200);

        // Only the beat carrying the outstanding tag writes, and only once
        drive(1'b1, 64'h200, 4'd0, 4'd2, 64'h1111);
        check_eq("t3_tag2_wr", 64'(wr1_en), 64'd0);
        check_eq("t3_tag2_valid", 64'(Icache_valid_out), 64'd0);
        drive(1'b1, 64'h200, 4'd0, 4'd7, 64'h2222);
        check_eq("t3_tag7_wr", 64'(wr1_en), 64'd0);
        drive(1'b1, 64'h200, 4'd0, 4'd5, mem_word(13'h40));
        check_eq("t3_tag5_wr", 64'(wr1_en), 64'd1);
        check_eq("t3_tag5_line", 64'({wr1_tag, wr1_idx}), 64'h40);
        check_eq("t3_tag5_data", wr1_data, mem_word(13'h40));
        check_eq("t3_byp_data", Icache_data_out, mem_word(13'h40));
        drive(1'b0, 64'h0, 4'd0, 4'd5, 64'h3333);
        check_eq("t3_repeat_wr", 64'(wr1_en), 64'd0);
        settle();

        // Reset while waiting for a fill; the late beat must be ignored
        drive(1'b1, 64'h280, 4'd0, 4'd0, 64'd0);
        drive(1'b1, 64'h280, 4'd6, 4'd0, 64'd0);
        check_eq("t4_req_cmd", 64'(proc2Imem_command), 64'(LOAD));
        drive(1'b0, 64'h0, 4'd0, 4'd0, 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        Imem2proc_tag  = 4'd6;
        Imem2proc_data = 64'h4444;
        #1;
        check_eq("t4_rst_cmd", 64'(proc2Imem_command), 64'd0);
        check_eq("t4_rst_wr", 64'(wr1_en), 64'd0);
        check_eq("t4_rst_addr", proc2Imem_addr, 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 64'h0, 4'd0, 4'd6, 64'h4444);
            check_eq("t4_late_wr", 64'(wr1_en), 64'd0);
            check_eq("t4_late_cmd", 64'(proc2Imem_command), 64'd0);
        end

        // Back-to-back hits on four filled lines
        hit_lines = '{64'h200, 64'h208, 64'h210, 64'h218};
        for (int i = 1; i < 4; i++) begin
            fill_line(hit_lines[i]);
            settle();
        end
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, hit_lines[c % 4] | 64'(c % 8), 4'd0, 4'd0, 64'd0);
            check_eq("t6_valid", 64'(Icache_valid_out), 64'd1);
            check_eq("t6_data", Icache_data_out, mem_word(hit_lines[c % 4][15:3]));
            check_eq("t6_cmd", 64'(proc2Imem_command), 64'd0);
        end

`ifdef ICACHE_PREFETCH_EN
        // Fill of idx 31 / tag 0 prefetches idx 0 / tag 1 and serves it by bypass
        drive(1'b1, 64'hF8, 4'd0, 4'd0, 64'd0);
        check_eq("pf_idle_cmd", 64'(proc2Imem_command), 64'd0);
        drive(1'b1, 64'hF8, 4'd4, 4'd0, 64'd0);
        check_eq("pf_req_addr", proc2Imem_addr, 64'hF8);
        drive(1'b1, 64'hF8, 4'd0, 4'd4, mem_word(13'h1F));
        check_eq("pf_dfill_wr", 64'(wr1_en), 64'd1);
        check_eq("pf_dfill_line", 64'({wr1_tag, wr1_idx}), 64'h1F);
        drive(1'b1, 64'hF8, 4'd7, 4'd0, 64'd0);
        check_eq("pf_cmd", 64'(proc2Imem_command), 64'(LOAD));
        check_eq("pf_addr", proc2Imem_addr, 64'h100);
        drive(1'b1, 64'h100, 4'd0, 4'd0, 64'd0);
        check_eq("pf_wait_valid", 64'(Icache_valid_out), 64'd0);
        check_eq("pf_wait_cmd", 64'(proc2Imem_command), 64'd0);
        drive(1'b1, 64'h100, 4'd0, 4'd7, mem_word(13'h20));
        check_eq("pf_fill_wr", 64'(wr1_en), 64'd1);
        check_eq("pf_fill_line", 64'({wr1_tag, wr1_idx}), 64'h20);
        check_eq("pf_byp_valid", 64'(Icache_valid_out), 64'd1);
        check_eq("pf_byp_data", Icache_data_out, mem_word(13'h20));
        drive(1'b1, 64'h100, 4'd0, 4'd0, 64'd0);
        check_eq("pf_hit_valid", 64'(Icache_valid_out), 64'd1);
        check_eq("pf_after_cmd", 64'(proc2Imem_command), 64'd0);
`endif

        // Randomized fetch stream against the array and memory models
        for (int f = 0; f < 150; f++) begin
            logic [63:0] a;
            int          limit;
            bit          hit;
            bit          got;
            a = {48'd0, 8'($urandom_range(0, 3)), idx_pool[$urandom_range(0, 5)], 3'($urandom)};
            limit = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 40;
            got = 1'b0;
            for (int c = 0; c < limit && !got; c++) begin
                mem_cycle(1'b1, a, 1'b1, 1'b0, hit);
                got = hit;
            end
            if (limit == 40) check_eq("fetch_done", 64'(got), 64'd1);
            if ($urandom_range(0, 3) == 0) mem_cycle(1'b0, 64'd0, 1'b1, 1'b0, hit);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
